// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - assembles and validates 5-byte UART command frames
module uart_cmd_parser #(
  parameter logic [7:0] SOF_BYTE       = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 500000,
  parameter int         TO_W           = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        rx_parity_error,
  output logic        cmd_valid,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        frame_error,
  output logic [7:0]  err_count,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, S_ADDR, S_DH, S_DL, S_CHK} state_t;

  state_t          state, state_next;
  logic            rx_ready_d;
  logic            byte_stb;
  logic [TO_W-1:0] timer;
  logic            timeout;
  logic [7:0]      addr_r, data_h_r, data_l_r;
  logic            cv_next, fe_next;

  // One byte per rising edge of rx_ready, whether it is a pulse or a held level
  assign byte_stb = rx_ready & ~rx_ready_d;
  // A byte arriving in the same cycle as the timeout takes priority
  assign timeout  = (state != IDLE) && !byte_stb &&
                    (timer == TO_W'(TIMEOUT_CYCLES - 1));

  // Edge-detect register for rx_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_ready_d <= 1'b0;
    else       rx_ready_d <= rx_ready;
  end

  // Inter-byte timer: idle at zero, restarted by every accepted strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          timer <= '0;
    else if (state == IDLE || byte_stb) timer <= '0;
    else                                timer <= timer + 1'b1;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and strobe decode
  always_comb begin
    state_next = state;
    cv_next    = 1'b0;
    fe_next    = 1'b0;
    if (state == IDLE) begin
      if (byte_stb && rx_data == SOF_BYTE && !rx_parity_error) state_next = S_ADDR;
    end else if (byte_stb) begin
      if (rx_parity_error) begin
        fe_next    = 1'b1;
        state_next = IDLE;
      end else begin
        case (state)
          S_ADDR:  state_next = S_DH;
          S_DH:    state_next = S_DL;
          S_DL:    state_next = S_CHK;
          S_CHK: begin
            if (rx_data == (addr_r ^ data_h_r ^ data_l_r)) cv_next = 1'b1;
            else                                           fe_next = 1'b1;
            state_next = IDLE;
          end
          default: state_next = IDLE;
        endcase
      end
    end else if (timeout) begin
      fe_next    = 1'b1;
      state_next = IDLE;
    end
  end

  // Capture frame payload bytes as they arrive
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r   <= '0;
      data_h_r <= '0;
      data_l_r <= '0;
    end else if (byte_stb && !rx_parity_error) begin
      case (state)
        S_ADDR:  addr_r   <= rx_data;
        S_DH:    data_h_r <= rx_data;
        S_DL:    data_l_r <= rx_data;
        default: ;
      endcase
    end
  end

  // Registered outputs: strobes, last good command, saturating error count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_valid   <= 1'b0;
      frame_error <= 1'b0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      err_count   <= '0;
      busy        <= 1'b0;
    end else begin
      cmd_valid   <= cv_next;
      frame_error <= fe_next;
      busy        <= (state_next != IDLE);
      if (cv_next) begin
        cmd_addr <= addr_r;
        cmd_data <= {data_h_r, data_l_r};
      end
      if (fe_next && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - randomized model-checked bench for uart_cmd_parser
module tb_uart_cmd_parser;
  localparam int         T   = 40;
  localparam logic [7:0] SOF = 8'hAA;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic        rx_parity_error = 1'b0;
  logic        cmd_valid;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        frame_error;
  logic [7:0]  err_count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cv     = 0;

  always #5 clk = ~clk;

  uart_cmd_parser #(.SOF_BYTE(SOF), .TIMEOUT_CYCLES(T), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_parity_error(rx_parity_error), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .frame_error(frame_error), .err_count(err_count), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame position, bytes so far, cycle of last accepted byte
  int          pos, m_cyc, m_last;
  logic [7:0]  fb [1:3];
  logic        m_prev, m_cv, m_fe, m_busy;
  logic [7:0]  m_addr, m_err;
  logic [15:0] m_data;

  task automatic m_error();
    m_fe = 1'b1;
    pos  = 0;
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
  endtask

  always @(posedge clk) begin
    m_cyc++;
    if (reset) begin
      pos = 0; m_prev = 0; m_cv = 0; m_fe = 0; m_busy = 0;
      m_addr = 0; m_err = 0; m_data = 0; m_last = 0;
    end else begin
      logic stb;
      stb    = rx_ready && !m_prev;
      m_prev = rx_ready;
      m_cv   = 0;
      m_fe   = 0;
      if (pos == 0) begin
        if (stb && rx_data == SOF && !rx_parity_error) begin
          pos = 1; m_last = m_cyc;
        end
      end else if (stb) begin
        m_last = m_cyc;
        if (rx_parity_error) m_error();
        else if (pos == 4) begin
          if (rx_data == (fb[1] ^ fb[2] ^ fb[3])) begin
            m_cv = 1; m_addr = fb[1]; m_data = {fb[2], fb[3]};
          end else m_error();
          pos = 0;
        end else begin
          fb[pos] = rx_data;
          pos++;
        end
      end else if (m_cyc - m_last >= T) begin
        m_error();
      end
      m_busy = (pos != 0);
    end
  end

  // Compare every cycle outside reset
  always @(negedge clk) begin
    if (!reset) begin
      chk("cmd_valid",   cmd_valid,   m_cv);
      chk("frame_error", frame_error, m_fe);
      chk("cmd_addr",    cmd_addr,    m_addr);
      chk("cmd_data",    cmd_data,    m_data);
      chk("err_count",   err_count,   m_err);
      chk("busy",        busy,        m_busy);
      if (cmd_valid) n_cv++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic p, input int hold, input int gap);
    @(negedge clk);
    rx_data = b; rx_parity_error = p; rx_ready = 1'b1;
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0; rx_parity_error = 1'b0; rx_data = 8'($urandom);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] c);
    send_byte(SOF, 0, 1, 2);
    send_byte(a, 0, 1, 2);
    send_byte(h, 0, 1, 2);
    send_byte(l, 0, 1, 2);
    send_byte(c, 0, 1, 2);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cv"},   cmd_valid,   0);
    chk({tag, "_fe"},   frame_error, 0);
    chk({tag, "_addr"}, cmd_addr,    0);
    chk({tag, "_data"}, cmd_data,    0);
    chk({tag, "_err"},  err_count,   0);
    chk({tag, "_busy"}, busy,        0);
  endtask

  initial begin
    int cv0;
    logic [7:0] fr [0:4];
    logic       pe [0:4];
    #1;
    chk_reset_outputs("rst0");
    idle(2);
    reset = 1'b0;

    // Good frame
    cv0 = n_cv;
    send_frame(8'h12, 8'h34, 8'h56, 8'h70);
    idle(3);
    chk("t1_cv_count", n_cv - cv0, 1);
    chk("t1_addr", cmd_addr, 8'h12);
    chk("t1_data", cmd_data, 16'h3456);
    chk("t1_err",  err_count, 0);

    // Bad checksum
    cv0 = n_cv;
    send_frame(8'h12, 8'h34, 8'h56, 8'h71);
    idle(3);
    chk("t2_err",  err_count, 1);
    chk("t2_addr", cmd_addr, 8'h12);
    chk("t2_data", cmd_data, 16'h3456);
    chk("t2_cv_count", n_cv - cv0, 0);

    // Junk before SOF
    cv0 = n_cv;
    send_byte(8'h55, 0, 1, 2);
    send_byte(8'h00, 0, 1, 2);
    send_frame(8'h01, 8'h02, 8'h03, 8'h00);
    idle(3);
    chk("t3_cv_count", n_cv - cv0, 1);
    chk("t3_addr", cmd_addr, 8'h01);
    chk("t3_data", cmd_data, 16'h0203);
    chk("t3_err",  err_count, 1);

    // Timeout, then recovery
    send_byte(SOF, 0, 1, 2);
    send_byte(8'h01, 0, 1, 2);
    idle(T + 3);
    chk("t4_err",  err_count, 2);
    chk("t4_busy", busy, 0);
    send_frame(8'h05, 8'h06, 8'h07, 8'h04);
    idle(3);
    chk("t4_addr", cmd_addr, 8'h05);
    chk("t4_data", cmd_data, 16'h0607);

    // Byte exactly T cycles after the previous one still counts
    cv0 = n_cv;
    send_byte(SOF, 0, 1, T - 1);
    send_byte(8'h11, 0, 1, T - 1);
    send_byte(8'h22, 0, 1, T - 1);
    send_byte(8'h33, 0, 1, T - 1);
    send_byte(8'h00, 0, 1, 2);
    idle(3);
    chk("edge_cv_count", n_cv - cv0, 1);
    chk("edge_err", err_count, 2);
    chk("edge_addr", cmd_addr, 8'h11);
    // One cycle later is a timeout; the late byte is discarded in IDLE
    send_byte(SOF, 0, 1, T);
    send_byte(8'h01, 0, 1, 2);
    idle(3);
    chk("late_err", err_count, 3);
    chk("late_busy", busy, 0);

    // Parity error on a held level: taken once
    send_byte(SOF, 0, 1, 2);
    send_byte(8'h01, 1, 10, 2);
    idle(3);
    chk("t5_err",  err_count, 4);
    chk("t5_busy", busy, 0);
    send_frame(8'h20, 8'h30, 8'h40, 8'h50);
    idle(3);
    chk("t5_addr", cmd_addr, 8'h20);

    // Randomized frames against the model
    for (int i = 0; i < 200; i++) begin
      int kind, k;
      kind = $urandom_range(0, 5);
      k    = $urandom_range(1, 4);
      if (kind == 4) send_byte(8'($urandom), 1'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
      fr[0] = SOF;
      for (int j = 1; j < 4; j++) fr[j] = 8'($urandom);
      fr[4] = fr[1] ^ fr[2] ^ fr[3];
      for (int j = 0; j < 5; j++) pe[j] = 1'b0;
      if (kind == 2) fr[4] = fr[4] ^ 8'($urandom_range(1, 255));
      if (kind == 3) pe[k] = 1'b1;
      for (int j = 0; j < 5; j++) begin
        int hold, gap;
        hold = $urandom_range(1, 3);
        gap  = $urandom_range(1, 4);
        if ($urandom_range(0, 15) == 0) gap = T - hold;
        if (kind == 5 && j == k - 1) gap = T - hold + $urandom_range(1, 3);
        send_byte(fr[j], pe[j], hold, gap);
      end
    end
    idle(T + 5);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      send_byte(SOF, 0, 1, 1);
      send_byte(8'h01, 0, 1, 1);
      send_byte(8'h02, 0, 1, 1);
      send_byte(8'h03, 0, 1, 1);
      send_byte(8'h01, 0, 1, 1);
    end
    idle(3);
    chk("t6_err_sat", err_count, 8'hFF);

    // Reset in mid-frame
    send_byte(SOF, 0, 1, 2);
    send_byte(8'h01, 0, 1, 2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    idle(2);
    reset = 1'b0;
    cv0 = n_cv;
    send_frame(8'h12, 8'h34, 8'h56, 8'h70);
    idle(3);
    chk("t6_cv_count", n_cv - cv0, 1);
    chk("t6_addr", cmd_addr, 8'h12);
    chk("t6_data", cmd_data, 16'h3456);
    chk("t6_err",  err_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
